// File: rtl/pulse_decoder.sv
// Measures y1 high-run / low-gap lengths and presents each pair as a record, latency 1, with a valid/ready hold.
// Records completing while one is held unaccepted are dropped and flag overrun; define PULSE_DECODER_SAT_EN for saturating counters.
module pulse_decoder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         y1_in,
    input  logic         rec_ready,
    output logic         rec_valid,
    output logic [W-1:0] rec_run,
    output logic [W-1:0] rec_gap,
    output logic         rec_sat,
    output logic         overrun
);

    typedef enum logic [1:0] {WAIT_LOW, ARMED, HIGH, LOW} state_t;

    state_t       state;
    logic [W-1:0] run_cnt;
    logic [W-1:0] gap_cnt;
    logic         complete;
    logic         xfer;

    assign complete = (state == LOW) && y1_in;
    assign xfer     = rec_valid && rec_ready;

`ifdef PULSE_DECODER_SAT_EN
    logic run_sat;
    logic gap_sat;
    logic rec_sat_r;

    assign rec_sat = rec_sat_r;
`else
    assign rec_sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_LOW;
            run_cnt   <= '0;
            gap_cnt   <= '0;
            rec_valid <= 1'b0;
            rec_run   <= '0;
            rec_gap   <= '0;
            overrun   <= 1'b0;
`ifdef PULSE_DECODER_SAT_EN
            run_sat   <= 1'b0;
            gap_sat   <= 1'b0;
            rec_sat_r <= 1'b0;
`endif
        end else begin
            case (state)
                WAIT_LOW: if (!y1_in) state <= ARMED;
                ARMED: if (y1_in) begin
                    state   <= HIGH;
                    run_cnt <= W'(1);
`ifdef PULSE_DECODER_SAT_EN
                    run_sat <= 1'b0;
`endif
                end
                HIGH: if (y1_in) begin
`ifdef PULSE_DECODER_SAT_EN
                    if (run_cnt == '1) run_sat <= 1'b1;
                    else               run_cnt <= run_cnt + W'(1);
`else
                    run_cnt <= run_cnt + W'(1);
`endif
                end else begin
                    state   <= LOW;
                    gap_cnt <= W'(1);
`ifdef PULSE_DECODER_SAT_EN
                    gap_sat <= 1'b0;
`endif
                end
                LOW: if (!y1_in) begin
`ifdef PULSE_DECODER_SAT_EN
                    if (gap_cnt == '1) gap_sat <= 1'b1;
                    else               gap_cnt <= gap_cnt + W'(1);
`else
                    gap_cnt <= gap_cnt + W'(1);
`endif
                end else begin
                    state   <= HIGH;
                    run_cnt <= W'(1);
`ifdef PULSE_DECODER_SAT_EN
                    run_sat <= 1'b0;
`endif
                end
                default: state <= WAIT_LOW;
            endcase

            // The output slot is free either when empty or when it drains on this very edge.
            if (complete && (!rec_valid || xfer)) begin
                rec_valid <= 1'b1;
                rec_run   <= run_cnt;
                rec_gap   <= gap_cnt;
`ifdef PULSE_DECODER_SAT_EN
                rec_sat_r <= run_sat | gap_sat;
`endif
            end else if (complete) begin
                overrun   <= 1'b1;
            end else if (xfer) begin
                rec_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_decoder.sv
// Directed bench for pulse_decoder: one task per scenario, inline expected-value checks.
module tb_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       y1_in = 1'b0;
    logic       rec_ready = 1'b0;
    logic       rec_valid;
    logic [7:0] rec_run;
    logic [7:0] rec_gap;
    logic       rec_sat;
    logic       overrun;

    int checks = 0;
    int errors = 0;

`ifdef PULSE_DECODER_SAT_EN
    localparam logic [7:0] LONG_RUN = 8'd255;
    localparam logic       LONG_SAT = 1'b1;
`else
    localparam logic [7:0] LONG_RUN = 8'd44;
    localparam logic       LONG_SAT = 1'b0;
`endif

    pulse_decoder #(.W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .y1_in    (y1_in),
        .rec_ready(rec_ready),
        .rec_valid(rec_valid),
        .rec_run  (rec_run),
        .rec_gap  (rec_gap),
        .rec_sat  (rec_sat),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v);
        y1_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic apply_reset(input logic y);
        rst = 1'b1;
        y1_in = y;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rec_ready = 1'b1;
        steps(1'b1, 2);
        steps(1'b0, 2);
        checks++;
        if ({rec_valid, rec_run, rec_gap, rec_sat, overrun} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b run=%0d gap=%0d sat=%b ovr=%b want all 0",
                     rec_valid, rec_run, rec_gap, rec_sat, overrun);
        end
    endtask

    task automatic test_basic();
        apply_reset(1'b0);
        rec_ready = 1'b1;
        steps(1'b0, 2);
        steps(1'b1, 3);
        steps(1'b0, 7);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid got %b want 0", rec_valid);
        end
        step(1'b1);
        checks++;
        if (rec_valid !== 1'b1 || rec_run !== 8'd3 || rec_gap !== 8'd7 || rec_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_record got v=%b run=%0d gap=%0d sat=%b want 1/3/7/0",
                     rec_valid, rec_run, rec_gap, rec_sat);
        end
        step(1'b1);
        checks++;
        if (rec_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL basic_drain got v=%b ovr=%b want 0/0", rec_valid, overrun);
        end
    endtask

    task automatic test_partial_run();
        apply_reset(1'b1);
        rec_ready = 1'b1;
        steps(1'b1, 4);
        steps(1'b0, 2);
        step(1'b1);
        steps(1'b0, 6);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL partial_ignored got v=%b want 0", rec_valid);
        end
        step(1'b1);
        checks++;
        if (rec_valid !== 1'b1 || rec_run !== 8'd1 || rec_gap !== 8'd6) begin
            errors++;
            $display("FAIL partial_record got v=%b run=%0d gap=%0d want 1/1/6", rec_valid, rec_run, rec_gap);
        end
    endtask

    task automatic test_overrun();
        apply_reset(1'b0);
        rec_ready = 1'b0;
        step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        step(1'b0); step(1'b0); step(1'b1);
        checks++;
        if (rec_valid !== 1'b1 || rec_run !== 8'd1 || rec_gap !== 8'd1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold got v=%b run=%0d gap=%0d ovr=%b want 1/1/1/1",
                     rec_valid, rec_run, rec_gap, overrun);
        end
        rec_ready = 1'b1;
        step(1'b1);
        checks++;
        if (rec_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky got v=%b ovr=%b want 0/1", rec_valid, overrun);
        end
        rec_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b0);
        rec_ready = 1'b0;
        step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        step(1'b1); step(1'b0); step(1'b0);
        checks++;
        if (rec_valid !== 1'b1 || rec_run !== 8'd1 || rec_gap !== 8'd1) begin
            errors++;
            $display("FAIL b2b_first got v=%b run=%0d gap=%0d want 1/1/1", rec_valid, rec_run, rec_gap);
        end
        rec_ready = 1'b1;
        step(1'b1);
        checks++;
        if (rec_valid !== 1'b1 || rec_run !== 8'd2 || rec_gap !== 8'd2 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload got v=%b run=%0d gap=%0d ovr=%b want 1/2/2/0",
                     rec_valid, rec_run, rec_gap, overrun);
        end
        step(1'b1);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got v=%b want 0", rec_valid);
        end
    endtask

    task automatic test_long_run();
        apply_reset(1'b0);
        rec_ready = 1'b1;
        step(1'b0);
        steps(1'b1, 300);
        steps(1'b0, 2);
        step(1'b1);
        checks++;
        if (rec_valid !== 1'b1 || rec_run !== LONG_RUN || rec_gap !== 8'd2 || rec_sat !== LONG_SAT) begin
            errors++;
            $display("FAIL long_run got v=%b run=%0d gap=%0d sat=%b want 1/%0d/2/%b",
                     rec_valid, rec_run, rec_gap, rec_sat, LONG_RUN, LONG_SAT);
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b0);
        rec_ready = 1'b0;
        step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        step(1'b0);
        checks++;
        if (rec_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pending got v=%b want 1", rec_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rec_valid, rec_run, rec_gap, rec_sat, overrun} !== 19'd0) begin
            errors++;
            $display("FAIL areset_async got v=%b run=%0d gap=%0d sat=%b ovr=%b want all 0",
                     rec_valid, rec_run, rec_gap, rec_sat, overrun);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0); step(1'b1); step(1'b0);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL areset_no_early got v=%b want 0", rec_valid);
        end
        step(1'b1);
        checks++;
        if (rec_valid !== 1'b1 || rec_run !== 8'd1 || rec_gap !== 8'd1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL areset_resume got v=%b run=%0d gap=%0d ovr=%b want 1/1/1/0",
                     rec_valid, rec_run, rec_gap, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial_run();
        test_overrun();
        test_back_to_back();
        test_long_run();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
